time_entry_ctrl: RTL and testbench

//  Sequences keypad time-setting for the watch timekeeper: captures the running time,

---
 rtl/watch_pkg.sv | 56 +++++
 rtl/key_edge_decode.sv | 34 +++
 rtl/time_entry_ctrl.sv | 154 +++++++++++++++
 tb/tb_time_entry_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-entry path.
package watch_pkg;

   typedef logic [3:0] bcd_t;

   // Element 5 is h_ten, element 0 is s_one, so the packed value reads HHMMSS.
   typedef bcd_t [5:0] time_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CAPTURE  = 3'd1,
      EDIT     = 3'd2,
      COMMIT   = 3'd3,
      WAIT_REL = 3'd4
   } entry_state_t;

   // Cursor values, left to right on the display.
   localparam logic [2:0] IDX_H_TEN = 3'd0;
   localparam logic [2:0] IDX_H_ONE = 3'd1;
   localparam logic [2:0] IDX_M_TEN = 3'd2;
   localparam logic [2:0] IDX_M_ONE = 3'd3;
   localparam logic [2:0] IDX_S_TEN = 3'd4;
   localparam logic [2:0] IDX_S_ONE = 3'd5;

   localparam bcd_t DIGIT_LIMIT [0:5] = '{4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};
   localparam bcd_t H_ONE_LIM_20H = 4'd3;

   // Observation struct: FSM state plus the working entry and blink phase.
   typedef struct packed {
      entry_state_t state;
      time_t        entry;
      logic         phase;
   } entry_dbg_t;

   // Map a cursor index to its element position inside time_t.
   function automatic logic [2:0] digit_pos(input logic [2:0] idx);
      return 3'd5 - idx;
   endfunction

   // blink_mask bit for the digit at a cursor index (bit5 = h_ten).
   function automatic logic [5:0] digit_bit(input logic [2:0] idx);
      return 6'b100000 >> idx;
   endfunction

   // Largest key accepted at a cursor; 20-23 h is the only dependent case.
   function automatic bcd_t digit_limit(input logic [2:0] idx, input bcd_t h_ten);
      bcd_t lim;
      lim = 4'd0;
      for (int i = 0; i < 6; i++) begin
         if (idx == 3'(i)) lim = DIGIT_LIMIT[i];
      end
      if (idx == IDX_H_ONE && h_ten == 4'd2) lim = H_ONE_LIM_20H;
      return lim;
   endfunction

endpackage

// File: rtl/key_edge_decode.sv
// Turns raw keypad lines into a single-cycle key event plus the digit value.
// An event needs exactly one line high now and all lines low last cycle, so
// held keys and chords never produce a second event.
module key_edge_decode (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] keypad,
   output logic       key_evt,
   output logic [3:0] key_digit
);

   logic [9:0] kp_prev;
   logic [3:0] ones;

   // Remember last cycle's key lines for release detection.
   always_ff @(posedge clk) begin
      if (rst) kp_prev <= '0;
      else     kp_prev <= keypad;
   end

   // Count active lines and encode the (last) active one.
   always_comb begin
      ones      = 4'd0;
      key_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (keypad[i]) begin
            ones      = ones + 4'd1;
            key_digit = 4'(i);
         end
      end
      key_evt = (ones == 4'd1) && (kp_prev == 10'd0);
   end

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad time-setting sequencer: captures the running time, walks a cursor
// over HH MM SS, range-checks each key and strobes the result into the
// timekeeper. load is a bare one-cycle strobe with no back-pressure: the
// timekeeper must take load_time on the cycle load=1; load_time then holds.
module time_entry_ctrl
   import watch_pkg::*;
#(
   parameter int CLK_HZ     = 1000,
   parameter int TIMEOUT_S  = 10,
   parameter int BLINK_HALF = 250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_mode,
   input  logic [9:0]  keypad,
   input  logic [23:0] cur_time,
   output logic        load,
   output logic [23:0] load_time,
   output logic [2:0]  cursor,
   output logic [5:0]  blink_mask,
   output logic        key_err,
   output logic        busy,
   output entry_dbg_t  dbg
);

   localparam int TO_CYCLES = CLK_HZ * TIMEOUT_S;
   localparam int TO_W = $clog2(TO_CYCLES);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYCLES - 1);
   localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_HALF - 1);

   entry_state_t    state;
   time_t           entry;
   logic            phase;
   logic [TO_W-1:0] to_cnt;
   logic [BL_W-1:0] bl_cnt;

   logic            key_evt;
   logic [3:0]      key_digit;
   logic [2:0]      cur_pos;
   logic            key_ok;

   key_edge_decode u_key (
      .clk       (clk),
      .rst       (rst),
      .keypad    (keypad),
      .key_evt   (key_evt),
      .key_digit (key_digit)
   );

   // Range check for the digit under the cursor.
   always_comb begin
      cur_pos = digit_pos(cursor);
      key_ok  = key_digit <= digit_limit(cursor, entry[5]);
   end

   // Main sequencer; blink_mask is updated together with phase/cursor so it is exact.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         entry      <= '0;
         cursor     <= '0;
         load       <= 1'b0;
         load_time  <= '0;
         blink_mask <= '0;
         key_err    <= 1'b0;
         busy       <= 1'b0;
         phase      <= 1'b0;
         to_cnt     <= '0;
         bl_cnt     <= '0;
      end else begin
         load    <= 1'b0;
         key_err <= 1'b0;
         case (state)
            IDLE: begin
               if (set_mode) begin
                  state <= CAPTURE;
                  busy  <= 1'b1;
               end
            end
            CAPTURE: begin
               entry      <= cur_time;
               cursor     <= IDX_H_TEN;
               to_cnt     <= '0;
               bl_cnt     <= '0;
               phase      <= 1'b0;
               blink_mask <= '0;
               state      <= EDIT;
            end
            EDIT: begin
               // Free-running blink step; later assignments below override it.
               if (bl_cnt == BL_MAX) begin
                  bl_cnt     <= '0;
                  phase      <= ~phase;
                  blink_mask <= phase ? 6'b000000 : digit_bit(cursor);
               end else begin
                  bl_cnt <= bl_cnt + 1'b1;
               end

               if (!set_mode) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  phase      <= 1'b0;
                  blink_mask <= '0;
               end else if (key_evt) begin
                  to_cnt <= '0;
                  if (key_ok) begin
                     entry[cur_pos] <= key_digit;
                     // 2x h with a stale h_one above 3 would be an invalid hour.
                     if (cursor == IDX_H_TEN && key_digit == 4'd2 && entry[4] > H_ONE_LIM_20H)
                        entry[4] <= 4'd0;
                     phase      <= 1'b0;
                     bl_cnt     <= '0;
                     blink_mask <= '0;
                     if (cursor == IDX_S_ONE) state  <= COMMIT;
                     else                     cursor <= cursor + 3'd1;
                  end else begin
                     key_err <= 1'b1;
                  end
               end else if (to_cnt == TO_MAX) begin
                  state      <= WAIT_REL;
                  phase      <= 1'b0;
                  blink_mask <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            COMMIT: begin
               load      <= 1'b1;
               load_time <= entry;
               state     <= WAIT_REL;
            end
            WAIT_REL: begin
               if (!set_mode) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Expose internal state for observation.
   always_comb begin
      dbg.state = state;
      dbg.entry = entry;
      dbg.phase = phase;
   end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed bench for time_entry_ctrl: a vector table for key sequences and
// hand-written sequences for timeout, abort, reset and blink timing.
module tb_time_entry_ctrl;
   import watch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        set_mode = 1'b0;
   logic [9:0]  keypad = '0;
   logic [23:0] cur_time = '0;
   logic        load;
   logic [23:0] load_time;
   logic [2:0]  cursor;
   logic [5:0]  blink_mask;
   logic        key_err;
   logic        busy;
   entry_dbg_t  dbg;

   int n_cmp = 0;
   int n_err = 0;
   int load_cnt = 0;
   logic [23:0] last_load = '0;

   localparam int OP_START = 0;
   localparam int OP_KEY   = 1;
   localparam int OP_ABORT = 2;

   typedef struct {
      int           op;
      logic [23:0]  arg;
      logic [2:0]   exp_cursor;
      logic         exp_err;
      logic [23:0]  exp_entry;
      entry_state_t exp_state;
   } vec_t;

   vec_t vecs[$];

   time_entry_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .set_mode   (set_mode),
      .keypad     (keypad),
      .cur_time   (cur_time),
      .load       (load),
      .load_time  (load_time),
      .cursor     (cursor),
      .blink_mask (blink_mask),
      .key_err    (key_err),
      .busy       (busy),
      .dbg        (dbg)
   );

   // Clock / reset block.
   always #5 clk = ~clk;

   // Load pulse monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (load) begin
         load_cnt  = load_cnt + 1;
         last_load = load_time;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Driver tasks.
   task automatic do_start(input logic [23:0] t);
      cur_time = t;
      set_mode = 1'b1;
      tick();
      tick();
   endtask

   task automatic press(input int d);
      keypad = 10'(1 << d);
      tick();
      keypad = '0;
      tick();
   endtask

   task automatic add_vec(input int op, input logic [23:0] arg, input logic [2:0] c,
                          input logic e, input logic [23:0] ent, input entry_state_t st);
      vec_t v;
      v.op = op; v.arg = arg; v.exp_cursor = c; v.exp_err = e;
      v.exp_entry = ent; v.exp_state = st;
      vecs.push_back(v);
   endtask

   initial begin
      int n;
      logic [5:0] exp_mask;

      // Test 1: full entry 23:59:07 from 12:34:56, key ignored in WAIT_REL.
      add_vec(OP_START, 24'h123456,     3'd0, 1'b0, 24'h123456, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 2), 3'd1, 1'b0, 24'h223456, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 3), 3'd2, 1'b0, 24'h233456, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 5), 3'd3, 1'b0, 24'h235456, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 9), 3'd4, 1'b0, 24'h235956, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 0), 3'd5, 1'b0, 24'h235906, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 7), 3'd5, 1'b0, 24'h235907, COMMIT);
      add_vec(OP_KEY,   24'(10'd1 << 1), 3'd5, 1'b0, 24'h235907, WAIT_REL);
      add_vec(OP_ABORT, 24'h0,          3'd5, 1'b0, 24'h235907, IDLE);
      // Test 2: range checks and the h_one clamp.
      add_vec(OP_START, 24'h073456,     3'd0, 1'b0, 24'h073456, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 3), 3'd0, 1'b1, 24'h073456, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 2), 3'd1, 1'b0, 24'h203456, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 4), 3'd1, 1'b1, 24'h203456, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 3), 3'd2, 1'b0, 24'h233456, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 6), 3'd2, 1'b1, 24'h233456, EDIT);
      add_vec(OP_KEY,   24'(10'd1 << 5), 3'd3, 1'b0, 24'h235456, EDIT);
      add_vec(OP_ABORT, 24'h0,          3'd3, 1'b0, 24'h235456, IDLE);
      // Test 3 (start): chord gives no event.
      add_vec(OP_START, 24'h123456,     3'd0, 1'b0, 24'h123456, EDIT);
      add_vec(OP_KEY,   24'h000006,     3'd0, 1'b0, 24'h123456, EDIT);

      // Reset state.
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset_load", 32'(load), 32'd0);
      check("reset_load_time", 32'(load_time), 32'd0);
      check("reset_cursor", 32'(cursor), 32'd0);
      check("reset_blink", 32'(blink_mask), 32'd0);
      check("reset_key_err", 32'(key_err), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_state", 32'(dbg.state), 32'(IDLE));

      // Table-driven vectors.
      foreach (vecs[i]) begin
         case (vecs[i].op)
            OP_START: begin
               cur_time = vecs[i].arg;
               set_mode = 1'b1;
               tick();
               check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
               tick();
            end
            OP_KEY: begin
               keypad = vecs[i].arg[9:0];
               tick();
            end
            default: begin
               set_mode = 1'b0;
               tick();
            end
         endcase
         check($sformatf("v%0d_cursor", i), 32'(cursor), 32'(vecs[i].exp_cursor));
         check($sformatf("v%0d_key_err", i), 32'(key_err), 32'(vecs[i].exp_err));
         check($sformatf("v%0d_entry", i), 32'(dbg.entry), 32'(vecs[i].exp_entry));
         check($sformatf("v%0d_state", i), 32'(dbg.state), 32'(vecs[i].exp_state));
         if (vecs[i].op == OP_KEY) begin
            keypad = '0;
            tick();
            check($sformatf("v%0d_err_clear", i), 32'(key_err), 32'd0);
         end
      end

      check("t1_load_count", 32'(load_cnt), 32'd1);
      check("t1_load_value", 32'(last_load), 32'h235907);
      check("t1_load_time_hold", 32'(load_time), 32'h235907);

      // Test 3: release one key of a chord, then a long hold.
      keypad = 10'b0000011000;
      tick();
      keypad = 10'b0000010000;
      tick();
      check("t3_chord_release_cursor", 32'(cursor), 32'd0);
      keypad = '0;
      tick();
      keypad = 10'b0000000001;
      repeat (50) tick();
      keypad = '0;
      tick();
      check("t3_hold_cursor", 32'(cursor), 32'd1);
      check("t3_hold_entry", 32'(dbg.entry), 32'h023456);
      set_mode = 1'b0;
      tick();
      check("t3_idle", 32'(dbg.state), 32'(IDLE));

      // Test 4: inactivity timeout after 3 digits.
      do_start(24'h123456);
      press(1); press(2); press(3);
      check("t4_cursor", 32'(cursor), 32'd3);
      n = 0;
      while (dbg.state != WAIT_REL && n < 12000) begin
         tick();
         n = n + 1;
      end
      check("t4_timeout_cycles", 32'(n), 32'd9999);
      check("t4_state", 32'(dbg.state), 32'(WAIT_REL));
      check("t4_no_load", 32'(load_cnt), 32'd1);
      check("t4_busy", 32'(busy), 32'd1);
      set_mode = 1'b0;
      tick();
      check("t4_idle", 32'(dbg.state), 32'(IDLE));

      // Test 5a: abort in the same cycle as the final key.
      do_start(24'h123456);
      press(2); press(3); press(5); press(9); press(0);
      check("t5_cursor5", 32'(cursor), 32'd5);
      keypad = 10'(1 << 7);
      set_mode = 1'b0;
      tick();
      keypad = '0;
      check("t5_abort_state", 32'(dbg.state), 32'(IDLE));
      tick(); tick();
      check("t5_abort_no_load", 32'(load_cnt), 32'd1);
      check("t5_abort_busy", 32'(busy), 32'd0);

      // Test 5b: reset mid-edit.
      do_start(24'h123456);
      press(1); press(2);
      rst = 1'b1;
      tick();
      check("t5_rst_load_time", 32'(load_time), 32'd0);
      check("t5_rst_cursor", 32'(cursor), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_blink", 32'(blink_mask), 32'd0);
      check("t5_rst_load", 32'(load), 32'd0);
      check("t5_rst_key_err", 32'(key_err), 32'd0);
      check("t5_rst_state", 32'(dbg.state), 32'(IDLE));
      check("t5_rst_entry", 32'(dbg.entry), 32'd0);
      set_mode = 1'b0;
      rst = 1'b0;
      tick();

      // Test 6: blink at cursor 2.
      do_start(24'h123456);
      press(1);
      keypad = 10'(1 << 2);
      tick();
      check("t6_cursor", 32'(cursor), 32'd2);
      check("t6_mask_after_key", 32'(blink_mask), 32'd0);
      keypad = '0;
      for (int k = 2; k <= 501; k++) begin
         tick();
         exp_mask = (k >= 251 && k <= 500) ? 6'b001000 : 6'b000000;
         if (blink_mask !== exp_mask) begin
            n_err = n_err + 1;
            $display("FAIL t6_blink offset %0d: got %b, expected %b", k, blink_mask, exp_mask);
         end
         n_cmp = n_cmp + 1;
      end
      set_mode = 1'b0;
      tick();
      check("t6_mask_idle", 32'(blink_mask), 32'd0);
      check("t6_final_loads", 32'(load_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
